branch_resolve_unit: RTL

- Execute-stage branch/jump resolution block; sole driver of the shared Comparator.
- Decodes RV32I funct3 into the package branch-select code and drives Comparator.sel, A and B from rs1/rs2.
- Registers the operands, computes the target address and drives a held valid/ready redirect to fetch.
- Squashes younger pipeline slots after a redirect and produces the JAL/JALR link value.

---
 rtl/branch_resolve_unit_pkg.sv | 23 ++
 rtl/branch_resolve_unit_comparator.sv | 22 ++
 rtl/branch_resolve_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// risc_v_32i: shared RV32I constants, branch-select codes and resolve-unit state type
package risc_v_32i;
  localparam int REG_SIZE = 32;
  localparam int BRANCH_SEL_LENGTH = 3;
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BEQ = 3'd0;
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BNE = 3'd1;
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BLT = 3'd2;
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BGE = 3'd3;
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BLTU = 3'd4;
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BGEU = 3'd5;
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BUNKNOWN = 3'd6;
  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_JAL = 2'd2;
  localparam logic [1:0] KIND_JALR = 2'd3;
  localparam logic [2:0] FUNCT3_BEQ = 3'b000;
  localparam logic [2:0] FUNCT3_BNE = 3'b001;
  localparam logic [2:0] FUNCT3_BLT = 3'b100;
  localparam logic [2:0] FUNCT3_BGE = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;
  typedef enum logic [1:0] {BRS_IDLE, BRS_EVAL, BRS_REDIRECT, BRS_FLUSH} brs_state_t;
endpackage

// File: rtl/branch_resolve_unit_comparator.sv
// Comparator: evaluates one branch condition between A and B; result[0] is the outcome
module Comparator
  import risc_v_32i::*;
(
  input  logic [BRANCH_SEL_LENGTH-1:0] sel,
  input  logic [REG_SIZE-1:0]          A,
  input  logic [REG_SIZE-1:0]          B,
  output logic [0:0]                   result
);
  logic eq, lt_s, lt_u;
  always_comb begin
    eq = A == B;
    lt_s = $signed(A) < $signed(B);
    lt_u = A < B;
    result[0] = sel == OP_BEQ  ? eq :
                sel == OP_BNE  ? !eq :
                sel == OP_BLT  ? lt_s :
                sel == OP_BGE  ? !lt_s :
                sel == OP_BLTU ? lt_u :
                sel == OP_BGEU ? !lt_u : 1'b0;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: execute-stage branch/jump resolution with held redirect,
// post-redirect flush window and JAL/JALR link value.
module branch_resolve_unit
  import risc_v_32i::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_kind,
  input  logic [2:0]           in_funct3,
  input  logic [REG_SIZE-1:0]  in_pc,
  input  logic [REG_SIZE-1:0]  in_imm,
  input  logic [REG_SIZE-1:0]  in_rs1,
  input  logic [REG_SIZE-1:0]  in_rs2,
  output logic                 redir_valid,
  input  logic                 redir_ready,
  output logic [REG_SIZE-1:0]  redir_pc,
  output logic                 link_valid,
  output logic [REG_SIZE-1:0]  link_data,
  output logic                 flush,
  output logic                 misalign_err,
  output logic [CNT_WIDTH-1:0] taken_count
);
  function automatic logic [BRANCH_SEL_LENGTH-1:0] decode_sel(input logic [2:0] f);
    return f == FUNCT3_BEQ  ? OP_BEQ :
           f == FUNCT3_BNE  ? OP_BNE :
           f == FUNCT3_BLT  ? OP_BLT :
           f == FUNCT3_BGE  ? OP_BGE :
           f == FUNCT3_BLTU ? OP_BLTU :
           f == FUNCT3_BGEU ? OP_BGEU : OP_BUNKNOWN;
  endfunction
  brs_state_t state_q, state_d;
  logic [REG_SIZE-1:0] pc_q, imm_q, rs1_q, rs2_q, jalr_sum, target;
  logic [1:0] kind_q;
  logic [BRANCH_SEL_LENGTH-1:0] sel_q;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;
  logic [0:0] cmp_result;
  logic taken, accept;
  Comparator u_cmp (.sel(sel_q), .A(rs1_q), .B(rs2_q), .result(cmp_result));
  assign accept = state_q == BRS_IDLE && in_valid && in_kind != KIND_NONE;
  assign jalr_sum = rs1_q + imm_q;
  assign target = kind_q == KIND_JALR ? {jalr_sum[REG_SIZE-1:1], 1'b0} : pc_q + imm_q;
  assign taken = (kind_q == KIND_BRANCH && cmp_result[0]) || kind_q == KIND_JAL || kind_q == KIND_JALR;
  assign in_ready = state_q == BRS_IDLE;
  assign redir_pc = redir_valid ? target : '0;
  assign link_data = link_valid ? pc_q + 32'd4 : '0;
  assign taken_count = taken_count_q;
  always_comb begin
    state_d = state_q;
    flush_cnt_d = flush_cnt_q;
    taken_count_d = taken_count_q;
    redir_valid = 1'b0;
    link_valid = 1'b0;
    misalign_err = 1'b0;
    flush = 1'b0;
    case (state_q)
      BRS_IDLE: state_d = accept ? BRS_EVAL : BRS_IDLE;
      BRS_EVAL: begin
        link_valid = kind_q == KIND_JAL || kind_q == KIND_JALR;
        misalign_err = taken && target[1:0] != 2'b00;
        redir_valid = taken && target[1:0] == 2'b00;
        state_d = !redir_valid ? BRS_IDLE : redir_ready ? BRS_FLUSH : BRS_REDIRECT;
      end
      BRS_REDIRECT: begin
        redir_valid = 1'b1;
        state_d = redir_ready ? BRS_FLUSH : BRS_REDIRECT;
      end
      BRS_FLUSH: begin
        flush = 1'b1;
        flush_cnt_d = flush_cnt_q - 3'd1;
        state_d = flush_cnt_q == 3'd0 ? BRS_IDLE : BRS_FLUSH;
      end
      default: state_d = BRS_IDLE;
    endcase
    // The handshake arms the flush window; the counter counts down the remaining cycles.
    if (redir_valid && redir_ready) begin
      taken_count_d = taken_count_q + CNT_WIDTH'(1);
      flush_cnt_d = 3'(FLUSH_DEPTH - 1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BRS_IDLE;
      pc_q <= '0;
      imm_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      kind_q <= KIND_NONE;
      sel_q <= '0;
      flush_cnt_q <= '0;
      taken_count_q <= '0;
    end else begin
      state_q <= state_d;
      flush_cnt_q <= flush_cnt_d;
      taken_count_q <= taken_count_d;
      if (accept) begin
        pc_q <= in_pc;
        imm_q <= in_imm;
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
        kind_q <= in_kind;
        sel_q <= decode_sel(in_funct3);
      end
    end
  end
endmodule
